// File: rtl/hmac_msg_sequencer.sv
// ---------------------------------------------------------------------------
// hmac_msg_sequencer
//
// Initiator-side feeder for an HMAC-384 core. Collects a big-endian 32-bit
// message word stream into 1024-bit blocks, applies SHA-384 final padding
// (the length field also counts the 1024-bit ipad key block the core hashes
// first), issues init/next commands and captures the final tag.
//
// Optional build macro: HMAC_SEQ_TAG_CMP_EN
//   When defined, adds input expected_tag and output tag_match. tag_match is
//   registered in DONE one cycle after tag_valid rises.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   zeroize                  synchronous clear of all state, buffer and tag
//   start, key_in            begin a new message (IDLE/DONE/ERROR), key sampled
//   msg_valid/ready/data/last/bytes   message beat stream
//   core_key, core_block     key/block held stable to the core
//   core_init, core_next     one-cycle commands (first / later blocks)
//   core_ready               core idle (sampled in ISSUE only)
//   core_tag_valid, core_tag core result
//   tag_out, tag_valid       final tag, level until start/zeroize
//   busy, error              activity, sticky protocol error
// ---------------------------------------------------------------------------
module hmac_msg_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           zeroize,
    input  logic           start,
    input  logic [383:0]   key_in,
    input  logic           msg_valid,
    output logic           msg_ready,
    input  logic [31:0]    msg_data,
    input  logic           msg_last,
    input  logic [2:0]     msg_bytes,
    output logic [383:0]   core_key,
    output logic [1023:0]  core_block,
    output logic           core_init,
    output logic           core_next,
    input  logic           core_ready,
    input  logic           core_tag_valid,
    input  logic [383:0]   core_tag,
`ifdef HMAC_SEQ_TAG_CMP_EN
    input  logic [383:0]   expected_tag,
    output logic           tag_match,
`endif
    output logic [383:0]   tag_out,
    output logic           tag_valid,
    output logic           busy,
    output logic           error
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_PADX, S_ISSUE, S_WAIT, S_DONE, S_ERROR
    } state_t;

    state_t          r_state;
    logic [1023:0]   r_buf;
    logic [383:0]    r_key;
    logic [383:0]    r_tag;
    logic            r_tag_valid;
    logic            r_error;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]      r_w;        // next word slot in the block
    logic            r_first;    // next command is core_init
    logic            r_final;    // block in flight is the last one
    logic            r_padx;     // an extra length-only block is owed
    logic            r_pad80;    // extra block starts with the 0x80 marker
    logic            r_init;
    logic            r_next;
`ifdef HMAC_SEQ_TAG_CMP_EN
    logic            r_tag_match;
`endif

    logic [CNT_W:0]  w_sum;
    logic [7:0]      w_used;
    logic            w_bad;
    logic [31:0]     w_word;
    logic [9:0]      w_wbase;
    logic [9:0]      w_bbase;
    logic [127:0]    w_len_fill;
    logic [127:0]    w_len_pad;
    logic [1023:0]   w_blk_wr;
    logic [1023:0]   w_blk_fin;

    assign w_sum   = {1'b0, r_cnt} + {{(CNT_W-2){1'b0}}, msg_bytes};
    // bytes in the current block once this beat lands
    assign w_used  = {1'b0, r_w, 2'b00} + {5'b00000, msg_bytes};
    assign w_bad   = (msg_bytes > 3'd4) | (!msg_last & (msg_bytes != 3'd4)) | w_sum[CNT_W];
    assign w_wbase = 10'd1023 - {r_w, 5'b00000};
    assign w_bbase = 10'd1023 - {w_used[6:0], 3'b000};

    // Length includes the 128-byte ipad block hashed ahead of the message.
    assign w_len_fill = (128'(w_sum[CNT_W-1:0]) + 128'd128) << 3;
    assign w_len_pad  = (128'(r_cnt) + 128'd128) << 3;

    // Keep only the valid leading bytes so stale lanes never leak into padding.
    always_comb begin
        w_word = msg_data;
        case (msg_bytes)
            3'd0:    w_word = 32'h0;
            3'd1:    w_word = msg_data & 32'hFF00_0000;
            3'd2:    w_word = msg_data & 32'hFFFF_0000;
            3'd3:    w_word = msg_data & 32'hFFFF_FF00;
            default: w_word = msg_data;
        endcase
    end

    always_comb begin
        w_blk_wr = r_buf;
        w_blk_wr[w_wbase -: 32] = w_word;
        w_blk_fin = w_blk_wr;
        if (w_used < 8'd128)
            w_blk_fin[w_bbase -: 8] = 8'h80;
        if (w_used <= 8'd111)
            w_blk_fin[127:0] = w_len_fill;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || zeroize) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_key       <= '0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
            r_error     <= 1'b0;
            r_cnt       <= '0;
            r_w         <= '0;
            r_first     <= 1'b0;
            r_final     <= 1'b0;
            r_padx      <= 1'b0;
            r_pad80     <= 1'b0;
            r_init      <= 1'b0;
            r_next      <= 1'b0;
`ifdef HMAC_SEQ_TAG_CMP_EN
            r_tag_match <= 1'b0;
`endif
        end else begin
            r_init <= 1'b0;
            r_next <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_key       <= key_in;
                        r_cnt       <= '0;
                        r_buf       <= '0;
                        r_w         <= '0;
                        r_first     <= 1'b1;
                        r_final     <= 1'b0;
                        r_padx      <= 1'b0;
                        r_pad80     <= 1'b0;
                        r_tag_valid <= 1'b0;
                        r_error     <= 1'b0;
`ifdef HMAC_SEQ_TAG_CMP_EN
                        r_tag_match <= 1'b0;
`endif
                        r_state     <= S_FILL;
                    end
`ifdef HMAC_SEQ_TAG_CMP_EN
                    else if (r_state == S_DONE) begin
                        r_tag_match <= (r_tag == expected_tag);
                    end
`endif
                end
                S_FILL: begin
                    if (msg_valid) begin
                        if (w_bad) begin
                            r_error <= 1'b1;
                            r_state <= S_ERROR;
                        end else begin
                            r_cnt <= w_sum[CNT_W-1:0];
                            r_w   <= r_w + 5'd1;
                            if (msg_last) begin
                                r_buf   <= w_blk_fin;
                                r_final <= (w_used <= 8'd111);
                                r_padx  <= (w_used > 8'd111);
                                r_pad80 <= (w_used == 8'd128);
                                r_state <= S_ISSUE;
                            end else begin
                                r_buf <= w_blk_wr;
                                if (r_w == 5'd31) begin
                                    r_final <= 1'b0;
                                    r_state <= S_ISSUE;
                                end
                            end
                        end
                    end
                end
                S_PADX: begin
                    r_buf   <= {(r_pad80 ? 8'h80 : 8'h00), 888'b0, w_len_pad};
                    r_final <= 1'b1;
                    r_padx  <= 1'b0;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (core_ready) begin
                        r_init  <= r_first;
                        r_next  <= !r_first;
                        r_first <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (core_tag_valid) begin
                        if (r_final) begin
                            r_tag       <= core_tag;
                            r_tag_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_buf   <= '0;
                            r_state <= r_padx ? S_PADX : S_FILL;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign msg_ready  = (r_state == S_FILL);
    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
    assign error      = r_error;
    assign core_key   = r_key;
    assign core_block = r_buf;
    assign core_init  = r_init;
    assign core_next  = r_next;
    assign tag_out    = r_tag;
    assign tag_valid  = r_tag_valid;
`ifdef HMAC_SEQ_TAG_CMP_EN
    assign tag_match  = r_tag_match;
`endif

endmodule

// File: tb/tb_hmac_msg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hmac_msg_sequencer: directed self-checking bench with a behavioural
// core model that records every command and answers with a tag.
// ---------------------------------------------------------------------------
module tb_hmac_msg_sequencer;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           zeroize = 1'b0;
    logic           start = 1'b0;
    logic [383:0]   key_in = '0;
    logic           msg_valid = 1'b0;
    logic           msg_ready;
    logic [31:0]    msg_data = '0;
    logic           msg_last = 1'b0;
    logic [2:0]     msg_bytes = 3'd0;
    logic [383:0]   core_key;
    logic [1023:0]  core_block;
    logic           core_init;
    logic           core_next;
    logic           core_ready = 1'b1;
    logic           core_tag_valid = 1'b0;
    logic [383:0]   core_tag;
    logic [383:0]   tag_out;
    logic           tag_valid;
    logic           busy;
    logic           error;
`ifdef HMAC_SEQ_TAG_CMP_EN
    logic [383:0]   expected_tag = '0;
    logic           tag_match;
`endif

    hmac_msg_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .zeroize(zeroize), .start(start),
        .key_in(key_in), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_data(msg_data), .msg_last(msg_last), .msg_bytes(msg_bytes),
        .core_key(core_key), .core_block(core_block), .core_init(core_init),
        .core_next(core_next), .core_ready(core_ready),
        .core_tag_valid(core_tag_valid), .core_tag(core_tag),
`ifdef HMAC_SEQ_TAG_CMP_EN
        .expected_tag(expected_tag), .tag_match(tag_match),
`endif
        .tag_out(tag_out), .tag_valid(tag_valid), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- core model ----------------
    logic [383:0]  core_tag_v = '0;
    int            tag_dly = 3;
    int            ncmd = 0;
    int            width_err = 0;
    int            cap_cyc = 0;
    int            dly = 0;
    logic          prev_cmd = 1'b0;
    logic [1023:0] cap_blk [0:3];
    logic          cap_init [0:3];
    logic [383:0]  cap_key = '0;

    assign core_tag = core_tag_v;

    always @(negedge clk) begin
        core_tag_valid = 1'b0;
        if (dly != 0) begin
            dly = dly - 1;
            if (dly == 0) core_tag_valid = 1'b1;
        end
        if (core_init || core_next) begin
            if (prev_cmd) width_err++;
            cap_blk[ncmd % 4]  = core_block;
            cap_init[ncmd % 4] = core_init;
            if (core_init) cap_key = core_key;
            cap_cyc = cyc;
            ncmd++;
            dly = tag_dly;
        end
        prev_cmd = core_init || core_next;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [383:0] k);
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [2:0] nb, input logic last,
                             output bit ok);
        int t;
        msg_valid = 1'b1;
        msg_data  = d;
        msg_bytes = nb;
        msg_last  = last;
        t = 0;
        while (!msg_ready && t < 200) begin
            tick();
            t++;
        end
        ok = msg_ready;
        tick();
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    // byte i of the pattern message is i+1; unused lanes carry 0xEE
    task automatic send_msg(input int n, output bit ok);
        int nbeats;
        bit b;
        logic [31:0] d;
        ok = 1'b1;
        nbeats = (n + 3) / 4;
        for (int k = 0; k < nbeats; k++) begin
            d = 32'hEEEE_EEEE;
            for (int j = 0; j < 4; j++)
                if (4*k + j < n) d[31-8*j -: 8] = 8'(4*k + j + 1);
            send_beat(d, (k == nbeats-1) ? 3'(n - 4*k) : 3'd4, k == nbeats-1, b);
            if (!b) ok = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok, output bit saw_rdy);
        ok = 1'b0;
        saw_rdy = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tag_valid) begin
                ok = 1'b1;
                break;
            end
            if (msg_ready) saw_rdy = 1'b1;
            tick();
        end
    endtask

    function automatic logic [1023:0] exp_blk(input int n, input bit with_len);
        logic [1023:0] e;
        e = '0;
        for (int i = 0; i < n; i++) e[1023-8*i -: 8] = 8'(i + 1);
        if (n < 128) e[1023-8*n -: 8] = 8'h80;
        if (with_len) e[127:0] = 128'((n + 128) * 8);
        return e;
    endfunction

    function automatic string bdiff(input logic [1023:0] a, input logic [1023:0] b);
        for (int i = 0; i < 128; i++)
            if (a[1023-8*i -: 8] !== b[1023-8*i -: 8])
                return $sformatf("byte %0d got %h want %h", i, a[1023-8*i -: 8], b[1023-8*i -: 8]);
        return "no byte differs";
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({msg_ready, core_init, core_next, tag_valid, busy, error} !== 6'b0 ||
            core_block !== '0 || core_key !== '0 || tag_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ctl=%b want 000000", {msg_ready, core_init, core_next, tag_valid, busy, error});
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || msg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b ready=%b want 0 0", busy, msg_ready);
        end
    endtask

    task automatic test_tc1();
        logic [383:0]  k;
        logic [383:0]  t;
        logic [1023:0] e;
        int base;
        bit ok, ok2, sr;
        k = {{20{8'h0b}}, 224'b0};
        t = 384'hafd03944d84895626b0825f4ab46907f15f9dadbe4101ec682aa034c7cebc59cfaea9ea9076ede7f4af152e8b2fa9cb6;
        e = '0;
        e[1023 -: 64] = 64'h4869205468657265;
        e[959 -: 8]   = 8'h80;
        e[127:0]      = 128'h440;
        core_tag_v = t;
        base = ncmd;
        do_start(k);
        send_beat(32'h48692054, 3'd4, 1'b0, ok);
        send_beat(32'h68657265, 3'd4, 1'b1, ok2);
        wait_done(ok, sr);
        checks++;
        if (!ok || !ok2) begin errors++; $display("FAIL tc1_done got tag_valid=%b want 1", tag_valid); end
        checks++;
        if (ncmd - base !== 1 || cap_init[base % 4] !== 1'b1) begin
            errors++; $display("FAIL tc1_cmds got %0d cmds want 1 init", ncmd - base);
        end
        checks++;
        if (cap_blk[base % 4] !== e) begin errors++; $display("FAIL tc1_block %s", bdiff(cap_blk[base % 4], e)); end
        checks++;
        if (cap_key !== k || core_key !== k) begin errors++; $display("FAIL tc1_key got %h want %h", cap_key, k); end
        checks++;
        if (tag_out !== t) begin errors++; $display("FAIL tc1_tag got %h want %h", tag_out, t); end
        checks++;
        if (busy !== 1'b0 || error !== 1'b0 || msg_ready !== 1'b0) begin
            errors++; $display("FAIL tc1_status got busy=%b err=%b rdy=%b want 0 0 0", busy, error, msg_ready);
        end
    endtask

    task automatic test_len_111_112();
        int base;
        bit ok, ok2, sr;
        logic [1023:0] e;
        // 111 bytes: everything fits, length 0x778
        core_tag_v = {12{32'h1111_0001}};
        base = ncmd;
        do_start({12{32'hA5A5_0111}});
        send_msg(111, ok2);
        wait_done(ok, sr);
        checks++;
        if (!ok || !ok2 || ncmd - base !== 1 || cap_init[base % 4] !== 1'b1) begin
            errors++; $display("FAIL len111_cmds got %0d cmds want 1 init", ncmd - base);
        end
        checks++;
        if (cap_blk[base % 4][127:0] !== 128'h778) begin
            errors++; $display("FAIL len111_length got %h want 778", cap_blk[base % 4][127:0]);
        end
        checks++;
        if (cap_blk[base % 4] !== exp_blk(111, 1'b1)) begin
            errors++; $display("FAIL len111_block %s", bdiff(cap_blk[base % 4], exp_blk(111, 1'b1)));
        end
        checks++;
        if (tag_out !== {12{32'h1111_0001}}) begin errors++; $display("FAIL len111_tag got %h want %h", tag_out, {12{32'h1111_0001}}); end
        // 112 bytes: marker fits, length spills into a second block
        core_tag_v = {12{32'h2222_0002}};
        base = ncmd;
        do_start({12{32'h5A5A_0112}});
        send_msg(112, ok2);
        wait_done(ok, sr);
        checks++;
        if (!ok || !ok2 || ncmd - base !== 2 || cap_init[base % 4] !== 1'b1 || cap_init[(base+1) % 4] !== 1'b0) begin
            errors++; $display("FAIL len112_cmds got %0d cmds want init+next", ncmd - base);
        end
        checks++;
        if (cap_blk[base % 4] !== exp_blk(112, 1'b0)) begin
            errors++; $display("FAIL len112_block0 %s", bdiff(cap_blk[base % 4], exp_blk(112, 1'b0)));
        end
        e = '0;
        e[127:0] = 128'h780;
        checks++;
        if (cap_blk[(base+1) % 4] !== e) begin
            errors++; $display("FAIL len112_block1 %s", bdiff(cap_blk[(base+1) % 4], e));
        end
    endtask

    task automatic test_len_128();
        int base;
        bit ok, ok2, sr;
        logic [1023:0] e;
        core_tag_v = {12{32'h3333_0003}};
        base = ncmd;
        do_start({12{32'h0F0F_0128}});
        send_msg(128, ok2);
        wait_done(ok, sr);
        checks++;
        if (!ok || !ok2 || ncmd - base !== 2 || cap_init[base % 4] !== 1'b1 || cap_init[(base+1) % 4] !== 1'b0) begin
            errors++; $display("FAIL len128_cmds got %0d cmds want init+next", ncmd - base);
        end
        checks++;
        if (cap_blk[base % 4] !== exp_blk(128, 1'b0)) begin
            errors++; $display("FAIL len128_block0 %s", bdiff(cap_blk[base % 4], exp_blk(128, 1'b0)));
        end
        e = '0;
        e[1023 -: 8] = 8'h80;
        e[127:0] = 128'h800;
        checks++;
        if (cap_blk[(base+1) % 4] !== e) begin
            errors++; $display("FAIL len128_block1 %s", bdiff(cap_blk[(base+1) % 4], e));
        end
        checks++;
        if (sr !== 1'b0) begin errors++; $display("FAIL len128_ready got msg_ready=1 after last beat want 0"); end
    endtask

    task automatic test_core_stall();
        int base, rise;
        bit ok, ok2, sr;
        core_tag_v = {12{32'h4444_0004}};
        core_ready = 1'b0;
        do_start({12{32'h1234_5678}});
        base = ncmd;
        send_msg(4, ok2);
        repeat (10) tick();
        checks++;
        if (!ok2 || ncmd !== base || busy !== 1'b1) begin
            errors++; $display("FAIL stall_nocmd got %0d cmds busy=%b want 0 cmds busy=1", ncmd - base, busy);
        end
        core_ready = 1'b1;
        rise = cyc;
        wait_done(ok, sr);
        checks++;
        if (!ok || ncmd - base !== 1 || cap_cyc !== rise + 1) begin
            errors++; $display("FAIL stall_cmd_cycle got %0d want %0d", cap_cyc, rise + 1);
        end
        checks++;
        if (width_err !== 0) begin errors++; $display("FAIL cmd_width got %0d wide pulses want 0", width_err); end
        checks++;
        if (tag_out !== {12{32'h4444_0004}}) begin errors++; $display("FAIL stall_tag got %h want %h", tag_out, {12{32'h4444_0004}}); end
    endtask

    task automatic test_error();
        int base;
        bit ok;
        base = ncmd;
        do_start({12{32'hDEAD_BEEF}});
        send_beat(32'h11223344, 3'd2, 1'b0, ok);
        checks++;
        if (!ok || error !== 1'b1 || msg_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL err_short got err=%b rdy=%b busy=%b want 1 0 0", error, msg_ready, busy);
        end
        repeat (5) tick();
        checks++;
        if (ncmd !== base) begin errors++; $display("FAIL err_nocmd got %0d cmds want 0", ncmd - base); end
        do_start({12{32'hDEAD_BEEF}});
        checks++;
        if (error !== 1'b0 || msg_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL err_restart got err=%b rdy=%b busy=%b want 0 1 1", error, msg_ready, busy);
        end
        send_beat(32'h11223344, 3'd5, 1'b1, ok);
        checks++;
        if (error !== 1'b1 || msg_ready !== 1'b0) begin
            errors++; $display("FAIL err_bytes5 got err=%b rdy=%b want 1 0", error, msg_ready);
        end
    endtask

    task automatic test_zeroize();
        int base;
        bit ok;
        tag_dly = 8;
        base = ncmd;
        do_start({12{32'hCAFE_0006}});
        send_msg(4, ok);
        for (int i = 0; i < 20; i++) begin
            if (ncmd != base) break;
            tick();
        end
        checks++;
        if (!ok || ncmd - base !== 1) begin errors++; $display("FAIL zero_precmd got %0d cmds want 1", ncmd - base); end
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        checks++;
        if (busy !== 1'b0 || tag_valid !== 1'b0 || core_block !== '0 || core_key !== '0 ||
            msg_ready !== 1'b0 || tag_out !== '0) begin
            errors++; $display("FAIL zero_clear got busy=%b tv=%b rdy=%b want 0 0 0", busy, tag_valid, msg_ready);
        end
        repeat (12) tick();
        checks++;
        if (tag_valid !== 1'b0 || busy !== 1'b0 || tag_out !== '0) begin
            errors++; $display("FAIL zero_late_tag got tv=%b busy=%b want 0 0", tag_valid, busy);
        end
        tag_dly = 3;
    endtask

    initial begin
        test_reset();
        test_tc1();
        test_len_111_112();
        test_len_128();
        test_core_stall();
        test_error();
        test_zeroize();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
